// File: rtl/seg_pkg.sv
// Purpose: shared register addresses, ctrl bit positions and blink-state encoding for seg_disp_ctrl.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package seg_pkg;

  // Register map selected by wr_addr
  localparam logic ADDR_DATA = 1'b0;
  localparam logic ADDR_CTRL = 1'b1;

  // Bit positions inside the ctrl register payload
  localparam int CTRL_COUNT_BIT = 0;
  localparam int CTRL_BLINK_BIT = 1;

  // Blink FSM encoding; SHOW is the reset state so digits are lit out of reset
  typedef enum logic {
    BLINK_SHOW  = 1'b0,
    BLINK_BLANK = 1'b1
  } blink_state_e;

endpackage

// File: rtl/seg_tick_gen.sv
// Purpose: free-running prescaler that emits a one-cycle tick every PRESCALE_DIV clk cycles.
// Latency: tick is decoded straight from the counter register (no extra stage).
// Backpressure: none; clr restarts the period from 0 on the next edge.
//
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset, clears the counter
//   clr   - synchronous restart of the counter to 0
//   tick  - high for the single cycle in which the counter equals PRESCALE_DIV-1
module seg_tick_gen #(
  parameter int PRESCALE_DIV = 25000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (PRESCALE_DIV > 2) ? $clog2(PRESCALE_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/seg_disp_ctrl.sv
// Purpose: two-digit 7-segment display register with auto-count and optional blink (macro SEG_BLINK_EN).
// Latency: an accepted write is visible on seg_data_* one cycle later.
// Backpressure: wr_ready is low only during reset; afterwards every wr_valid is accepted.
//
// Ports:
//   clk, rst_n             - clock (rising edge) and asynchronous active-low reset
//   wr_valid/wr_ready      - write handshake; a write happens on an edge with both high
//   wr_addr                - 0 = data register, 1 = ctrl register (bit0 count_en, bit1 blink_en)
//   wr_data[7:0]           - write payload
//   seg_data_1/seg_data_2  - low / high nibble of the data register
//   seg_on                 - digit enable (blink output); constant 1 without SEG_BLINK_EN
//   tick                   - one-cycle prescaler pulse
module seg_disp_ctrl
  import seg_pkg::*;
#(
  parameter int PRESCALE_DIV = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic       wr_addr,
  input  logic [7:0] wr_data,
  output logic [3:0] seg_data_1,
  output logic [3:0] seg_data_2,
  output logic       seg_on,
  output logic       tick
);

  logic       wr_ready_q;
  logic       wr_ready_d;
  logic [7:0] disp_q;
  logic [7:0] disp_d;
  logic       count_en_q;
  logic       count_en_d;

  logic       wr_fire;
  logic       data_wr;
  logic       ctrl_wr;
  logic       tick_w;

  // The handshake uses the registered ready, so nothing from wr_* reaches the outputs combinationally
  assign wr_fire = wr_valid && wr_ready_q;
  assign data_wr = wr_fire && (wr_addr == ADDR_DATA);
  assign ctrl_wr = wr_fire && (wr_addr == ADDR_CTRL);

  seg_tick_gen #(
    .PRESCALE_DIV(PRESCALE_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (ctrl_wr),
    .tick (tick_w)
  );

  always_comb begin
    wr_ready_d = 1'b1;
    count_en_d = count_en_q;
    disp_d     = disp_q;
    // A written value wins over a coincident count increment
    if (data_wr) begin
      disp_d = wr_data;
    end else if (tick_w && count_en_q) begin
      disp_d = disp_q + 8'd1;
    end
    if (ctrl_wr) begin
      count_en_d = wr_data[CTRL_COUNT_BIT];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ready_q <= 1'b0;
      disp_q     <= 8'h00;
      count_en_q <= 1'b0;
    end else begin
      wr_ready_q <= wr_ready_d;
      disp_q     <= disp_d;
      count_en_q <= count_en_d;
    end
  end

`ifdef SEG_BLINK_EN
  logic         blink_en_q;
  logic         blink_en_d;
  blink_state_e blink_state_q;
  blink_state_e blink_state_d;

  always_comb begin
    blink_en_d = blink_en_q;
    if (ctrl_wr) begin
      blink_en_d = wr_data[CTRL_BLINK_BIT];
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_en_q    <= 1'b0;
      blink_state_q <= BLINK_SHOW;
    end else begin
      blink_en_q    <= blink_en_d;
      blink_state_q <= blink_state_d;
    end
  end

  // Next state: a ctrl write or disabled blink pins the digits on; otherwise toggle per tick
  always_comb begin
    blink_state_d = blink_state_q;
    if (ctrl_wr || !blink_en_q) begin
      blink_state_d = BLINK_SHOW;
    end else if (tick_w) begin
      case (blink_state_q)
        BLINK_SHOW:  blink_state_d = BLINK_BLANK;
        BLINK_BLANK: blink_state_d = BLINK_SHOW;
        default:     blink_state_d = BLINK_SHOW;
      endcase
    end
  end

  // Output decode
  always_comb begin
    seg_on = 1'b1;
    if (blink_state_q == BLINK_BLANK) begin
      seg_on = 1'b0;
    end
  end
`else
  assign seg_on = 1'b1;
`endif

  assign wr_ready   = wr_ready_q;
  assign seg_data_1 = disp_q[3:0];
  assign seg_data_2 = disp_q[7:4];
  assign tick       = tick_w;

endmodule

// File: tb/tb_seg_disp_ctrl.sv
// Purpose: self-checking bench for seg_disp_ctrl with PRESCALE_DIV=4 against a behavioural model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: wr_valid driven directly; the model applies the ready it holds from the previous cycle.
module tb_seg_disp_ctrl;

  localparam int DIV = 4;

  logic       clk;
  logic       rst_n;
  logic       wr_valid;
  logic       wr_ready;
  logic       wr_addr;
  logic [7:0] wr_data;
  logic [3:0] seg_data_1;
  logic [3:0] seg_data_2;
  logic       seg_on;
  logic       tick;

  int tests = 0;
  int fails = 0;

  // Behavioural model: display value as an integer, position inside the tick period, flags
  int m_disp;
  int m_phase;
  bit m_cen;
  bit m_ben;
  bit m_show;
  bit m_ready;

  seg_disp_ctrl #(
    .PRESCALE_DIV(DIV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .seg_data_1(seg_data_1),
    .seg_data_2(seg_data_2),
    .seg_on    (seg_on),
    .tick      (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_disp  = 0;
    m_phase = 0;
    m_cen   = 1'b0;
    m_ben   = 1'b0;
    m_show  = 1'b1;
    m_ready = 1'b0;
  endtask

  // Advance one clock edge and apply the rules to the model with the inputs seen at that edge
  task automatic step();
    bit acc;
    bit tk;
    @(posedge clk);
    #1;
    acc = wr_valid && m_ready;
    tk  = (m_phase == DIV - 1);
    if (acc && !wr_addr)  m_disp = wr_data;
    else if (tk && m_cen) m_disp = (m_disp + 1) % 256;
`ifdef SEG_BLINK_EN
    if ((acc && wr_addr) || !m_ben) m_show = 1'b1;
    else if (tk)                    m_show = !m_show;
`endif
    if (acc && wr_addr) begin
      m_cen   = wr_data[0];
      m_ben   = wr_data[1];
      m_phase = 0;
    end else begin
      m_phase = (m_phase + 1) % DIV;
    end
    m_ready = 1'b1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".wr_ready"}, wr_ready, m_ready);
    chk({tag, ".seg1"}, seg_data_1, m_disp % 16);
    chk({tag, ".seg2"}, seg_data_2, m_disp / 16);
    chk({tag, ".tick"}, tick, (m_phase == DIV - 1));
    chk({tag, ".seg_on"}, seg_on, m_show);
  endtask

  task automatic wr(input logic a, input logic [7:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    step();
    wr_valid = 1'b0;
  endtask

  initial begin
    bit found;
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = 1'b0;
    wr_data  = 8'h00;
    model_reset();

    // Held in reset across an edge
    #12;
    chk("rst.wr_ready", wr_ready, 1'b0);
    chk("rst.seg1", seg_data_1, 4'h0);
    chk("rst.seg2", seg_data_2, 4'h0);
    chk("rst.seg_on", seg_on, 1'b1);
    chk("rst.tick", tick, 1'b0);

    // Release between edges; first edge raises ready, tick occupies the 4th cycle
    #1 rst_n = 1'b1;
    step();
    chk("rel1.wr_ready", wr_ready, 1'b1);
    chk("rel1.tick", tick, 1'b0);
    check_all("rel1");
    step();
    chk("rel2.tick", tick, 1'b0);
    step();
    chk("rel3.tick", tick, 1'b1);
    step();
    chk("rel4.tick", tick, 1'b0);
    check_all("rel4");

    // Plain data write, then an unvalidated payload must not land
    wr(1'b0, 8'hA5);
    chk("wr_a5.seg2", seg_data_2, 4'hA);
    chk("wr_a5.seg1", seg_data_1, 4'h5);
    wr_data = 8'h3C;
    wr_addr = 1'b0;
    step();
    chk("novalid.seg", {seg_data_2, seg_data_1}, 8'hA5);
    check_all("novalid");

    // Count mode wrapping through 0xFF
    wr(1'b0, 8'hFE);
    wr(1'b1, 8'h01);
    repeat (8) step();
    chk("cnt2.disp", {seg_data_2, seg_data_1}, 8'h00);
    repeat (4) step();
    chk("cnt3.disp", {seg_data_2, seg_data_1}, 8'h01);
    check_all("cnt3");

    // Data write colliding with a counting tick keeps the written value
    wr(1'b1, 8'h01);
    repeat (3) step();
    chk("coll.tick", tick, 1'b1);
    wr(1'b0, 8'h40);
    chk("coll.disp", {seg_data_2, seg_data_1}, 8'h40);
    step();
    chk("coll.hold", {seg_data_2, seg_data_1}, 8'h40);
    wr(1'b1, 8'h00);
    check_all("coll");

    // Blink: toggles every 4 cycles when enabled
    wr(1'b1, 8'h02);
    chk("blink0.seg_on", seg_on, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      step();
`ifdef SEG_BLINK_EN
      chk("blink.seg_on", seg_on, (i >= 4 && i < 8) ? 1'b0 : 1'b1);
`else
      chk("noblink.seg_on", seg_on, 1'b1);
`endif
      check_all("blink");
    end
    repeat (4) step();
`ifdef SEG_BLINK_EN
    chk("blink12.seg_on", seg_on, 1'b0);
`else
    chk("noblink12.seg_on", seg_on, 1'b1);
`endif
    wr(1'b1, 8'h00);
    chk("blinkoff.seg_on", seg_on, 1'b1);
    check_all("blinkoff");

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      wr_valid = ($urandom_range(0, 3) == 0);
      wr_addr  = ($urandom_range(0, 7) == 0);
      wr_data  = 8'($urandom_range(0, 255));
      step();
      check_all("rand");
    end
    wr_valid = 1'b0;

    // Reset asserted mid-count / mid-blink acts without a clock edge
    wr(1'b0, 8'h77);
    wr(1'b1, 8'h03);
    found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (!found) begin
        step();
        check_all("preblank");
`ifdef SEG_BLINK_EN
        if (seg_on == 1'b0) found = 1'b1;
`else
        if (tick == 1'b1) found = 1'b1;
`endif
      end
    end
    chk("midrst.reached", found, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst.seg_on", seg_on, 1'b1);
    chk("midrst.disp", {seg_data_2, seg_data_1}, 8'h00);
    check_all("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_all("postrst");
    repeat (8) begin
      step();
      check_all("postrst_run");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
